// File: rtl/sram_pkg.sv
// Shared constants for sram_pdp and its FIFO controller.
// DEPTH/WIDTH are the default geometry; AW is the SRAM address width,
// PW the FIFO pointer width (address plus one wrap bit) and CW the
// occupancy count width (0..DEPTH needs one bit more than the address).
package sram_pkg;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int CW    = AW + 1;
endpackage

// File: rtl/sram_fifo_ptr.sv
// Wrap-bit pointer for the SRAM FIFO controller.
// Ports:
//   clk    - clock, updates on posedge
//   rst    - asynchronous active-high reset, clears the pointer
//   i_inc  - advance the pointer by one at the next edge
//   o_ptr  - current pointer; low bits address the SRAM, MSB is the wrap bit
// The pointer simply counts modulo 2^PW, so the low bits roll from
// depth-1 to 0 and the wrap bit toggles at the same time.
module sram_fifo_ptr #(
  parameter int PW = sram_pkg::PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);
  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/sram_pdp_fifo_ctrl.sv
// FIFO controller in front of a pseudo-dual-port SRAM (sram_pdp).
// Writes go out on SRAM port A, reads on port B; the SRAM read is
// synchronous so read data comes back one cycle after a read is accepted.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   wr_en, wr_data      - upstream write request and data
//   full                - registered; writes are refused while high
//   rd_en               - downstream read request
//   rd_data, rd_valid   - read data (held between reads) and its 1-cycle strobe
//   empty               - registered; reads are refused while high
//   count               - registered occupancy, 0..depth
//   wr_err, rd_err      - 1-cycle pulses after a refused write / read
//   cs, we_A, add_A, data_inA, re_B, add_B - SRAM control (combinational)
//   data_outB           - SRAM read data, valid the cycle after re_B
// Handshake: a write is accepted on any edge where wr_en=1 and full=0;
// a read is accepted on any edge where rd_en=1 and empty=0. Both decisions
// use the flags registered at the start of the cycle, so a write into an
// empty FIFO never falls through to a read in the same cycle.
module sram_pdp_fifo_ctrl
  import sram_pkg::*;
#(
  parameter int depth = DEPTH,
  parameter int width = WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [width-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [width-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic [$clog2(depth):0]   count,
  output logic                     wr_err,
  output logic                     rd_err,
  output logic                     cs,
  output logic                     we_A,
  output logic [$clog2(depth)-1:0] add_A,
  output logic [width-1:0]         data_inA,
  output logic                     re_B,
  output logic [$clog2(depth)-1:0] add_B,
  input  logic [width-1:0]         data_outB
);
  localparam int LAW = $clog2(depth);
  localparam int LPW = LAW + 1;

  logic [LPW-1:0]   w_wr_ptr;
  logic [LPW-1:0]   w_rd_ptr;
  logic [LPW-1:0]   w_wr_nxt;
  logic [LPW-1:0]   w_rd_nxt;
  logic             w_wa;
  logic             w_ra;

  logic [LPW-1:0]   r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_rd_valid;
  logic             r_wr_err;
  logic             r_rd_err;
  logic [width-1:0] r_hold;

  assign w_wa = wr_en & ~r_full;
  assign w_ra = rd_en & ~r_empty;

  sram_fifo_ptr #(.PW(LPW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wa),
    .o_ptr (w_wr_ptr)
  );

  sram_fifo_ptr #(.PW(LPW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_ra),
    .o_ptr (w_rd_ptr)
  );

  // Pointer values after this edge; flags and count are derived from them
  // so they are correct in the very next cycle.
  assign w_wr_nxt = w_wr_ptr + {{(LPW-1){1'b0}}, w_wa};
  assign w_rd_nxt = w_rd_ptr + {{(LPW-1){1'b0}}, w_ra};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
      r_rd_err   <= 1'b0;
      r_hold     <= '0;
    end else begin
      // Modulo-2^LPW difference of the pointers is exactly the occupancy.
      r_count    <= w_wr_nxt - w_rd_nxt;
      r_empty    <= (w_wr_nxt == w_rd_nxt);
      r_full     <= (w_wr_nxt[LAW-1:0] == w_rd_nxt[LAW-1:0]) &&
                    (w_wr_nxt[LAW] != w_rd_nxt[LAW]);
      r_rd_valid <= w_ra;
      r_wr_err   <= wr_en & r_full;
      r_rd_err   <= rd_en & r_empty;
      if (r_rd_valid) begin
        r_hold <= data_outB;
      end
    end
  end

  assign we_A     = w_wa;
  assign add_A    = w_wr_ptr[LAW-1:0];
  assign data_inA = wr_data;
  assign re_B     = w_ra;
  assign add_B    = w_rd_ptr[LAW-1:0];
  assign cs       = w_wa | w_ra;

  // Fresh SRAM data passes straight through on the valid cycle; otherwise
  // the last delivered word is held.
  assign rd_data  = r_rd_valid ? data_outB : r_hold;
  assign rd_valid = r_rd_valid;
  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign wr_err   = r_wr_err;
  assign rd_err   = r_rd_err;
endmodule

// File: tb/tb_sram_pdp_fifo_ctrl.sv
module tb_sram_pdp_fifo_ctrl;
  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         rd_en = 1'b0;
  logic         full, empty, rd_valid, wr_err, rd_err, cs, we_A, re_B;
  logic [W-1:0] rd_data, data_inA;
  logic [W-1:0] data_outB = '0;
  logic [3:0]   count;
  logic [2:0]   add_A, add_B;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sram_pdp_fifo_ctrl #(.depth(D), .width(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .count(count), .wr_err(wr_err), .rd_err(rd_err), .cs(cs), .we_A(we_A),
    .add_A(add_A), .data_inA(data_inA), .re_B(re_B), .add_B(add_B),
    .data_outB(data_outB)
  );

  // Behavioural sram_pdp: synchronous write on A, synchronous read on B.
  logic [W-1:0] mem [D];
  initial for (int i = 0; i < D; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (we_A) mem[add_A] <= data_inA;
    if (re_B) data_outB <= mem[add_B];
  end

  // ---------------- reference model + scoreboard ----------------
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] m_q[$];        // FIFO contents as the specification defines them
  logic [W-1:0] exp_q[$];      // words expected on rd_data, in order
  logic [W-1:0] last_rd = '0;
  bit           exp_wr_err = 0, exp_rd_err = 0, prev_ra = 0;
  int           wr_total = 0, rd_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected word whenever the DUT presents rd_valid.
  always @(negedge clk) begin
    if (rst) begin
      last_rd = '0;
    end else if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", 1, 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e);
        last_rd = e;
      end
    end else begin
      chk("rd_data_hold", rd_data, last_rd);
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1: checks registered state, drives one
  // cycle of requests, checks SRAM controls, updates the model, steps.
  task automatic cycle(input bit we, input logic [W-1:0] wd, input bit re);
    bit m_full, m_empty, wa, ra;
    chk("count", count, m_q.size());
    chk("full", full, m_q.size() == D);
    chk("empty", empty, m_q.size() == 0);
    chk("wr_err", wr_err, exp_wr_err);
    chk("rd_err", rd_err, exp_rd_err);
    chk("rd_valid", rd_valid, prev_ra);
    wr_en = we; wr_data = wd; rd_en = re;
    m_full  = (m_q.size() == D);
    m_empty = (m_q.size() == 0);
    wa = we && !m_full;
    ra = re && !m_empty;
    #1;
    chk("we_A", we_A, wa);
    chk("re_B", re_B, ra);
    chk("cs", cs, wa || ra);
    if (wa) begin
      chk("add_A", add_A, wr_total % D);
      chk("data_inA", data_inA, wd);
    end
    if (ra) chk("add_B", add_B, rd_total % D);
    exp_wr_err = we && m_full;
    exp_rd_err = re && m_empty;
    prev_ra = ra;
    if (ra) begin
      exp_q.push_back(m_q.pop_front());
      rd_total++;
    end
    if (wa) begin
      m_q.push_back(wd);
      wr_total++;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    m_q.delete(); exp_q.delete();
    exp_wr_err = 0; exp_rd_err = 0; prev_ra = 0;
    wr_total = 0; rd_total = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk); #1;
    apply_reset();

    // 1: three writes then three reads
    cycle(1, 8'h11, 0); cycle(1, 8'h22, 0); cycle(1, 8'h33, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1);
    cycle(0, '0, 0);

    // 2: fill to full, overflow attempt, drain
    for (int i = 0; i < 8; i++) cycle(1, 8'hA0 + 8'(i), 0);
    cycle(1, 8'hEE, 0);
    for (int i = 0; i < 8; i++) cycle(0, '0, 1);

    // 3: underflow attempt
    cycle(0, '0, 1);
    cycle(0, '0, 0);

    // 4: fill to 4, 20 simultaneous pairs (pointers wrap)
    for (int i = 0; i < 4; i++) cycle(1, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 20; i++) cycle(1, 8'(i * 7 + 3), 1);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1);

    // 5: simultaneous while empty, then simultaneous while full
    cycle(0, '0, 0);
    cycle(1, 8'h5A, 1);
    cycle(0, '0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 8'hC0 + 8'(i), 0);
    cycle(1, 8'hDD, 1);
    cycle(0, '0, 0);
    for (int i = 0; i < 7; i++) cycle(0, '0, 1);

    // 6: reset the cycle after a read accept
    cycle(1, 8'h77, 0);
    cycle(1, 8'h78, 0);
    cycle(0, '0, 1);
    apply_reset();
    cycle(0, '0, 0);
    cycle(0, '0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int p;
      p = (i < 200) ? 70 : 35;  // bias toward filling, then toward draining
      cycle($urandom_range(99) < p, 8'($urandom), $urandom_range(99) >= p - 15);
    end
    for (int i = 0; i < 10; i++) cycle(0, '0, 1);
    cycle(0, '0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
